// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift/rotate controller. It accepts one operation per
// start_valid/start_ready handshake and applies the shift in chunks of at most
// STEP bit positions per clock. It then holds the result under a
// result_valid/result_ready handshake until the consumer takes it.
//
// The first chunk is applied on the accept edge. A shift of N bits therefore
// presents result_valid max(1, ceil(N/STEP)) cycles after the accept.
//
// Ports
//   clock         in   rising-edge clock
//   clear         in   synchronous active-low reset
//   start_valid   in   request present
//   start_ready   out  request can be accepted (IDLE only)
//   op            in   000 shr, 001 shra, 010 shl, 011 ror, 100 rol, others invalid
//   data_in       in   operand
//   shift_amount  in   shift distance, 0..WIDTH-1
//   abort         in   cancel an operation that is still shifting
//   result        out  shifted value, meaningful while result_valid
//   result_valid  out  result available (HOLD)
//   result_ready  in   consumer takes the result
//   busy          out  SHIFT or HOLD
//   err           out  invalid op, qualified by result_valid
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               abort,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               err
);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_work;
  logic [SHAMT_W-1:0]   r_remain;
  logic                 r_start_ready;
  logic                 r_result_valid;
  logic                 r_busy;
  logic                 r_err;

  // Bits shifted this clock: min(STEP, remaining).
  function automatic logic [SHAMT_W-1:0] chunk_len(input logic [SHAMT_W-1:0] f_rem);
    return (f_rem > STEP_K) ? STEP_K : f_rem;
  endfunction

  // One bounded shift of f_k positions. For shra the working register keeps
  // the operand's original sign bit in its MSB, so an arithmetic shift of the
  // partial result keeps filling with that sign on every chunk.
  function automatic logic [WIDTH-1:0] shift_chunk(
    input logic [2:0]         f_op,
    input logic [WIDTH-1:0]   f_val,
    input logic [SHAMT_W-1:0] f_k
  );
    logic [2*WIDTH-1:0]      dbl;
    logic [2*WIDTH-1:0]      tmp;
    logic signed [WIDTH-1:0] sval;
    dbl  = {f_val, f_val};
    tmp  = '0;
    sval = $signed(f_val);
    case (f_op)
      OP_SHR:  return f_val >> f_k;
      OP_SHRA: return $unsigned(sval >>> f_k);
      OP_SHL:  return f_val << f_k;
      OP_ROR: begin
        tmp = dbl >> f_k;
        return tmp[WIDTH-1:0];
      end
      OP_ROL: begin
        tmp = dbl << f_k;
        return tmp[2*WIDTH-1:WIDTH];
      end
      default: return f_val;
    endcase
  endfunction

  logic                 w_op_invalid;
  logic [SHAMT_W-1:0]   w_k_in;
  logic [WIDTH-1:0]     w_work_in;
  logic [SHAMT_W-1:0]   w_rem_in;
  logic [SHAMT_W-1:0]   w_k_step;
  logic [WIDTH-1:0]     w_work_step;
  logic [SHAMT_W-1:0]   w_rem_step;

  // First chunk, applied on the accept edge.
  assign w_op_invalid = (op > OP_ROL);
  assign w_k_in       = chunk_len(shift_amount);
  assign w_work_in    = shift_chunk(op, data_in, w_k_in);
  assign w_rem_in     = shift_amount - w_k_in;

  // Subsequent chunks while in SHIFT.
  assign w_k_step     = chunk_len(r_remain);
  assign w_work_step  = shift_chunk(r_op, r_work, w_k_step);
  assign w_rem_step   = r_remain - w_k_step;

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state        <= S_IDLE;
      r_op           <= OP_SHR;
      r_work         <= '0;
      r_remain       <= '0;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_op          <= op;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            if (w_op_invalid || (shift_amount == '0)) begin
              // Invalid op or zero shift: pass the operand straight to HOLD.
              r_work         <= data_in;
              r_remain       <= '0;
              r_err          <= w_op_invalid;
              r_result_valid <= 1'b1;
              r_state        <= S_HOLD;
            end else begin
              r_work   <= w_work_in;
              r_remain <= w_rem_in;
              r_err    <= 1'b0;
              if (w_rem_in == '0) begin
                r_result_valid <= 1'b1;
                r_state        <= S_HOLD;
              end else begin
                r_state <= S_SHIFT;
              end
            end
          end
        end

        S_SHIFT: begin
          if (abort) begin
            // Abort beats a simultaneous final step: no result is produced.
            r_state        <= S_IDLE;
            r_remain       <= '0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_result_valid <= 1'b0;
          end else begin
            r_work   <= w_work_step;
            r_remain <= w_rem_step;
            if (w_rem_step == '0) begin
              r_result_valid <= 1'b1;
              r_state        <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // result keeps its value after exit; only the qualifiers drop.
          if (result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_remain       <= '0;
          r_start_ready  <= 1'b1;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_err          <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign result       = r_work;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Bench for shift_sequencer. An abstract model derives each expected result
// with a single full-width shift and tracks only the operation phase and the
// remaining latency. A negedge process compares every output against it, and
// directed sequences pin literal values and latencies.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;

  logic               clock = 1'b0;
  logic               clear;
  logic               start_valid;
  logic               start_ready;
  logic [2:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               abort;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic               result_ready;
  logic               busy;
  logic               err;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
    .clock        (clock),
    .clear        (clear),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .abort        (abort),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Whole shift computed in one step.
  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] x, input int sa);
    logic signed [31:0] s;
    s = x;
    case (o)
      3'd0: return x >> sa;
      3'd1: return s >>> sa;
      3'd2: return x << sa;
      3'd3: return (sa == 0) ? x : ((x >> sa) | (x << (32 - sa)));
      3'd4: return (sa == 0) ? x : ((x << sa) | (x >> (32 - sa)));
      default: return x;
    endcase
  endfunction

  // Model: phase (0 idle, 1 busy shifting, 2 holding) plus cycles to go.
  int          m_mode  = 0;
  int          m_cnt   = 0;
  bit          m_known = 1'b0;
  logic [31:0] m_res   = '0;
  logic        m_err   = 1'b0;

  always @(posedge clock) begin
    int lat;
    bit bad;
    if (!clear) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_res   = '0;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      case (m_mode)
        0: if (start_valid) begin
          bad   = (op > 3'd4);
          m_res = ref_shift(op, data_in, int'(shift_amount));
          m_err = bad;
          lat   = (bad || shift_amount == 0) ? 1 : (int'(shift_amount) + STEP - 1) / STEP;
          if (lat == 1) m_mode = 2;
          else begin
            m_mode = 1;
            m_cnt  = lat - 1;
          end
        end
        1: if (abort) begin
          m_mode = 0;
          m_err  = 1'b0;
        end else begin
          m_cnt--;
          if (m_cnt == 0) m_mode = 2;
        end
        default: if (result_ready) begin
          m_mode = 0;
          m_err  = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_known) begin
      chk("cyc_start_ready", 32'(start_ready), 32'(m_mode == 0));
      chk("cyc_busy", 32'(busy), 32'(m_mode != 0));
      chk("cyc_result_valid", 32'(result_valid), 32'(m_mode == 2));
      chk("cyc_err", 32'(err), 32'((m_mode == 2) && m_err));
      if (m_mode == 2) chk("cyc_result", result, m_res);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op from IDLE, measure latency, check the result, then drain it.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] d,
                        input int sa, input logic [31:0] er, input logic ee, input int el);
    int lat;
    bit got;
    start_valid  = 1'b1;
    op           = o;
    data_in      = d;
    shift_amount = 5'(sa);
    tick();
    start_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_latency"}, 32'(lat), 32'(el));
      chk({nm, "_result"}, result, er);
      chk({nm, "_err"}, 32'(err), 32'(ee));
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    bit got;
    clear        = 1'b0;
    start_valid  = 1'b0;
    op           = 3'd0;
    data_in      = '0;
    shift_amount = '0;
    abort        = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    clear = 1'b1;

    // Reset state
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);

    // Literal expectations
    run_op("shra31", 3'd1, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0, 8);
    run_op("shr4", 3'd0, 32'h8000_0000, 4, 32'h0800_0000, 1'b0, 1);
    run_op("shl0", 3'd2, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1);
    run_op("ror5", 3'd3, 32'h0000_00F1, 5, 32'h8800_0007, 1'b0, 2);
    run_op("rol1", 3'd4, 32'h8000_0001, 1, 32'h0000_0003, 1'b0, 1);
    run_op("shl9", 3'd2, 32'h0000_0001, 9, 32'h0000_0200, 1'b0, 3);
    run_op("invalid", 3'b110, 32'hDEAD_BEEF, 7, 32'hDEAD_BEEF, 1'b1, 1);

    // Backpressure in HOLD with a competing request held.
    start_valid  = 1'b1;
    op           = 3'd2;
    data_in      = 32'h0000_0001;
    shift_amount = 5'd8;
    tick();
    op           = 3'd0;
    data_in      = 32'hF0F0_F0F0;
    shift_amount = 5'd4;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("bp_reach_hold", 32'(got), 32'd1);
    held = result;
    chk("bp_result", held, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid_held", 32'(result_valid), 32'd1);
      chk("bp_result_stable", result, held);
      chk("bp_no_ready", 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp_exit_idle", 32'(start_ready), 32'd1);
    chk("bp_exit_busy", 32'(busy), 32'd0);
    tick();
    start_valid = 1'b0;
    chk("bp_second_valid", 32'(result_valid), 32'd1);
    chk("bp_second_result", result, 32'h0F0F_0F0F);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Abort on the second SHIFT cycle of a 20-bit shift.
    start_valid  = 1'b1;
    op           = 3'd0;
    data_in      = 32'hFFFF_0000;
    shift_amount = 5'd20;
    tick();
    start_valid = 1'b0;
    tick();
    chk("ab_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(start_ready), 32'd1);
    chk("ab_err", 32'(err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("ab_no_valid", 32'(result_valid), 32'd0);
      tick();
    end

    // Same, cancelled by reset instead.
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_ready", 32'(start_ready), 32'd1);
    chk("clr_valid", 32'(result_valid), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_result", result, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clear        = ($urandom_range(0, 199) != 0);
      start_valid  = $urandom_range(0, 1);
      op           = 3'($urandom_range(0, 7));
      data_in      = $urandom;
      shift_amount = 5'($urandom_range(0, 31));
      abort        = ($urandom_range(0, 15) == 0);
      result_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    clear        = 1'b1;
    start_valid  = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
